// File: rtl/prim_prio_arb_pkg.sv
// Shared types and constants for the priority arbiter/scheduler.
package prim_prio_arb_pkg;

  typedef enum logic [0:0] {
    ArbIdle = 1'b0,
    ArbBusy = 1'b1
  } arb_state_e;

  localparam int BusyCntWidth = 16;

endpackage

// File: rtl/prim_max_tree.sv
// Binary max-tree over NumSrc keyed sources; equal keys resolve to the lower index.
module prim_max_tree #(
  parameter int NumSrc   = 8,
  parameter int Width    = 8,
  parameter int IdxWidth = $clog2(NumSrc)
) (
  input  logic [NumSrc-1:0][Width-1:0] values_i,
  input  logic [NumSrc-1:0]            valid_i,
  output logic [IdxWidth-1:0]          max_idx_o,
  output logic                         max_valid_o
);

  localparam int NumLevels = $clog2(NumSrc);
  localparam int NumLeaves = 2 ** NumLevels;

  logic [NumLeaves-1:0][Width-1:0]    node_val;
  logic [NumLeaves-1:0][IdxWidth-1:0] node_idx;
  logic [NumLeaves-1:0]               node_vld;

  // Each level folds pairs (2i, 2i+1) into node i; the right child wins only on a strictly larger key.
  always_comb begin
    node_val = '0;
    node_idx = '0;
    node_vld = '0;
    for (int i = 0; i < NumSrc; i++) begin
      node_val[i] = values_i[i];
      node_idx[i] = IdxWidth'(i);
      node_vld[i] = valid_i[i];
    end
    for (int lvl = 0; lvl < NumLevels; lvl++) begin
      for (int i = 0; i < (NumLeaves >> (lvl + 1)); i++) begin
        if (node_vld[2*i+1] && (!node_vld[2*i] || (node_val[2*i+1] > node_val[2*i]))) begin
          node_val[i] = node_val[2*i+1];
          node_idx[i] = node_idx[2*i+1];
          node_vld[i] = 1'b1;
        end else begin
          node_val[i] = node_val[2*i];
          node_idx[i] = node_idx[2*i];
          node_vld[i] = node_vld[2*i];
        end
      end
    end
  end

  assign max_idx_o   = node_vld[0] ? node_idx[0] : '0;
  assign max_valid_o = node_vld[0];

endmodule

// File: rtl/prim_prio_arb_sched.sv
// Priority scheduler for one shared resource: {prio, age} max-tree arbitration,
// grant held until the owner releases, per-requester anti-starvation aging.
module prim_prio_arb_sched
  import prim_prio_arb_pkg::*;
#(
  parameter int NumReq    = 8,
  parameter int PrioWidth = 3,
  parameter int AgeWidth  = 4,
  localparam int IdxWidth = $clog2(NumReq)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                en_i,
  input  logic [NumReq-1:0]                   req_i,
  input  logic [NumReq-1:0]                   rel_i,
  input  logic [NumReq-1:0][PrioWidth-1:0]    prio_i,
  output logic [NumReq-1:0]                   gnt_o,
  output logic                                gnt_valid_o,
  output logic [IdxWidth-1:0]                 gnt_idx_o,
  output logic [BusyCntWidth-1:0]             busy_cycles_o,
  output arb_state_e                          state_o
);

  // Handshake: req_i is a level held by a requester for as long as it wants the
  // resource; the owner gives it up by pulsing rel_i or by dropping req_i. A
  // grant appears on gnt_o the cycle after the winning request is sampled and
  // stays put until that release; rel_i from anyone but the owner is ignored.

  localparam int KeyWidth = PrioWidth + AgeWidth;
  localparam logic [AgeWidth-1:0]     AgeMax  = '1;
  localparam logic [BusyCntWidth-1:0] BusyMax = '1;

  arb_state_e                       state_q, state_d;
  logic [NumReq-1:0]                gnt_q, gnt_d;
  logic [IdxWidth-1:0]              owner_q, owner_d;
  logic [NumReq-1:0][AgeWidth-1:0]  age_q;
  logic [NumReq-1:0][KeyWidth-1:0]  key;
  logic [NumReq-1:0]                cand;
  logic                             rel_hit;
  logic [IdxWidth-1:0]              win_idx;
  logic                             win_valid;
  logic [BusyCntWidth-1:0]          busy_q;

  // gnt_q doubles as the owner mask, so the releasing owner drops out of its own re-arbitration.
  always_comb begin
    rel_hit = (state_q == ArbBusy) && |(gnt_q & (rel_i | ~req_i));
    cand    = '0;
    if (state_q == ArbIdle) begin
      cand = req_i & {NumReq{en_i}};
    end else if (rel_hit) begin
      cand = req_i & {NumReq{en_i}} & ~gnt_q;
    end
    for (int k = 0; k < NumReq; k++) begin
      key[k] = {prio_i[k], age_q[k]};
    end
  end

  prim_max_tree #(
    .NumSrc  (NumReq),
    .Width   (KeyWidth),
    .IdxWidth(IdxWidth)
  ) u_max_tree (
    .values_i   (key),
    .valid_i    (cand),
    .max_idx_o  (win_idx),
    .max_valid_o(win_valid)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    case (state_q)
      ArbIdle: begin
        if (win_valid) begin
          state_d = ArbBusy;
          gnt_d   = {{(NumReq-1){1'b0}}, 1'b1} << win_idx;
          owner_d = win_idx;
        end
      end
      ArbBusy: begin
        if (rel_hit) begin
          if (win_valid) begin
            gnt_d   = {{(NumReq-1){1'b0}}, 1'b1} << win_idx;
            owner_d = win_idx;
          end else begin
            state_d = ArbIdle;
            gnt_d   = '0;
            owner_d = '0;
          end
        end
      end
      default: begin
        state_d = ArbIdle;
        gnt_d   = '0;
        owner_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ArbIdle;
      gnt_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
    end
  end

  // Ages freeze while arbitration is disabled so a paused scheduler keeps its fairness history.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      age_q <= '0;
    end else if (en_i) begin
      for (int k = 0; k < NumReq; k++) begin
        if (!req_i[k] || (win_valid && (win_idx == IdxWidth'(k)))) begin
          age_q[k] <= '0;
        end else if (!gnt_q[k] && (age_q[k] != AgeMax)) begin
          age_q[k] <= age_q[k] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= '0;
    end else if (|gnt_q && (busy_q != BusyMax)) begin
      busy_q <= busy_q + 1'b1;
    end
  end

  assign gnt_o         = gnt_q;
  assign gnt_valid_o   = |gnt_q;
  assign gnt_idx_o     = owner_q;
  assign busy_cycles_o = busy_q;
  assign state_o       = state_q;

  a_gnt_onehot0: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(gnt_q));
  a_gnt_valid:   assert property (@(posedge clk_i) gnt_valid_o == (|gnt_o));
  a_gnt_idx:     assert property (@(posedge clk_i) disable iff (rst_i)
                   gnt_valid_o ? gnt_q[owner_q] : (owner_q == '0));
  a_gnt_hold:    assert property (@(posedge clk_i) disable iff (rst_i)
                   (state_q == ArbBusy && !rel_hit) |=> $stable(gnt_q));

endmodule

// File: tb/tb_prim_prio_arb_sched.sv
// Directed bench for prim_prio_arb_sched: driver pushes hand-computed grants per
// cycle into a queue; an independent monitor pops and compares each cycle.
module tb_prim_prio_arb_sched;
  import prim_prio_arb_pkg::*;

  localparam int ExpW = 32 + 8 + 16;

  logic            clk = 1'b0;
  logic            rst_i;
  logic            en_i;
  logic [7:0]      req_i;
  logic [7:0]      rel_i;
  logic [7:0][2:0] prio_i;
  logic [7:0]      gnt_o;
  logic            gnt_valid_o;
  logic [2:0]      gnt_idx_o;
  logic [15:0]     busy_cycles_o;
  arb_state_e      state_o;

  logic [ExpW-1:0] exp_q[$];
  int              n_chk = 0;
  int              n_err = 0;
  int unsigned     cyc_cnt = 0;
  logic [7:0]      cur_gnt_exp = 8'h00;
  logic [15:0]     busy_exp = 16'h0000;
  logic [ExpW-1:0] mon_e;
  logic [7:0]      mon_gnt;
  logic [15:0]     mon_busy;

  prim_prio_arb_sched #(
    .NumReq   (8),
    .PrioWidth(3),
    .AgeWidth (4)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .en_i         (en_i),
    .req_i        (req_i),
    .rel_i        (rel_i),
    .prio_i       (prio_i),
    .gnt_o        (gnt_o),
    .gnt_valid_o  (gnt_valid_o),
    .gnt_idx_o    (gnt_idx_o),
    .busy_cycles_o(busy_cycles_o),
    .state_o      (state_o)
  );

  // Clock and cycle stamp.
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [2:0] oh_to_idx(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc_cnt, act, exp);
    end
  endtask

  // Driver: apply one cycle of inputs and queue the grant expected after the next edge.
  task automatic step(input logic rst, input logic en, input logic [7:0] req,
                      input logic [7:0] rel, input logic [7:0] exp_gnt);
    logic [15:0] nb;
    @(posedge clk);
    #1;
    rst_i = rst;
    en_i  = en;
    req_i = req;
    rel_i = rel;
    if (rst) nb = 16'h0000;
    else if ((cur_gnt_exp != 8'h00) && (busy_exp != 16'hFFFF)) nb = busy_exp + 16'd1;
    else nb = busy_exp;
    exp_q.push_back({cyc_cnt + 32'd1, exp_gnt, nb});
    cur_gnt_exp = exp_gnt;
    busy_exp    = nb;
  endtask

  // Monitor / scoreboard.
  initial forever begin
    @(negedge clk);
    while ((exp_q.size() > 0) && (exp_q[0][ExpW-1 -: 32] <= cyc_cnt)) begin
      mon_e    = exp_q.pop_front();
      mon_gnt  = mon_e[23:16];
      mon_busy = mon_e[15:0];
      check("gnt_o", int'(gnt_o), int'(mon_gnt));
      check("gnt_valid_o", int'(gnt_valid_o), int'(mon_gnt != 8'h00));
      check("gnt_idx_o", int'(gnt_idx_o), int'(oh_to_idx(mon_gnt)));
      check("busy_cycles_o", int'(busy_cycles_o), int'(mon_busy));
      check("state_o", int'(state_o), (mon_gnt != 8'h00) ? int'(ArbBusy) : int'(ArbIdle));
    end
  end

  initial begin
    rst_i  = 1'b1;
    en_i   = 1'b0;
    req_i  = 8'h00;
    rel_i  = 8'h00;
    prio_i = '0;

    // Reset values.
    step(1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
    step(1'b1, 1'b1, 8'h00, 8'h00, 8'h00);

    // Basic grant, hold, owner release; rel_i in IDLE ignored.
    step(1'b0, 1'b1, 8'h04, 8'h00, 8'h04);
    repeat (4) step(1'b0, 1'b1, 8'h04, 8'h00, 8'h04);
    step(1'b0, 1'b1, 8'h04, 8'h04, 8'h00);
    step(1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
    step(1'b0, 1'b1, 8'h00, 8'hFF, 8'h00);

    // Priority and lowest-index tie-break, back-to-back handover, releaser excluded.
    prio_i[0] = 3'd3;
    prio_i[1] = 3'd5;
    prio_i[2] = 3'd5;
    prio_i[3] = 3'd1;
    step(1'b0, 1'b1, 8'h0F, 8'h00, 8'h02);
    step(1'b0, 1'b1, 8'h0F, 8'h00, 8'h02);
    step(1'b0, 1'b1, 8'h0D, 8'h00, 8'h04);
    step(1'b0, 1'b1, 8'h0D, 8'h04, 8'h01);
    step(1'b0, 1'b1, 8'h00, 8'h00, 8'h00);

    // Aging: idx7 waits 20 cycles (saturates at 15), idx6 waits 10; equal prio so
    // saturated idx7 must beat idx6, and the releasing high-prio idx0 is excluded.
    prio_i    = '0;
    prio_i[0] = 3'd1;
    step(1'b0, 1'b1, 8'h01, 8'h00, 8'h01);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, (i >= 10) ? 8'hC1 : 8'h81, 8'h00, 8'h01);
    step(1'b0, 1'b1, 8'hC1, 8'h01, 8'h80);
    step(1'b0, 1'b1, 8'h41, 8'h00, 8'h01);
    step(1'b0, 1'b1, 8'h00, 8'h00, 8'h00);

    // Foreign release ignored; en_i low keeps grant, then idles until re-enabled.
    prio_i = '0;
    step(1'b0, 1'b1, 8'h08, 8'h00, 8'h08);
    step(1'b0, 1'b1, 8'h28, 8'h20, 8'h08);
    step(1'b0, 1'b0, 8'h28, 8'h00, 8'h08);
    step(1'b0, 1'b0, 8'h28, 8'h08, 8'h00);
    step(1'b0, 1'b0, 8'h28, 8'h00, 8'h00);
    step(1'b0, 1'b1, 8'h28, 8'h00, 8'h20);
    step(1'b0, 1'b1, 8'h00, 8'h00, 8'h00);

    // Reset mid-grant, re-arbitration one cycle after reset drops.
    step(1'b0, 1'b1, 8'h10, 8'h00, 8'h10);
    repeat (9) step(1'b0, 1'b1, 8'h10, 8'h00, 8'h10);
    step(1'b1, 1'b1, 8'h10, 8'h00, 8'h00);
    step(1'b0, 1'b1, 8'h10, 8'h00, 8'h10);
    step(1'b0, 1'b1, 8'h00, 8'h00, 8'h00);

    // Busy counter saturation and hold after release.
    step(1'b0, 1'b1, 8'h01, 8'h00, 8'h01);
    for (int i = 0; i < 70000; i++) step(1'b0, 1'b1, 8'h01, 8'h00, 8'h01);
    step(1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
    step(1'b0, 1'b1, 8'h00, 8'h00, 8'h00);

    for (int i = 0; (i < 10) && (exp_q.size() > 0); i++) @(negedge clk);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected entries left unchecked, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
